// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryptor: expands its round keys after reset, then runs
// one inverse round per enabled clock on each block accepted via valid/ready.
module aes_dec_iter #(
    parameter logic [127:0] KEY = 128'h000102030405060708090A0B0C0D0E0F
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [127:0] Din,
    input  logic         Din_valid,
    output logic         Din_ready,
    output logic [127:0] Dout,
    output logic         Dout_valid
);

    typedef enum logic [1:0] {KEYGEN, IDLE, ROUND} state_t;

    state_t       state, state_nx;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] rk [0:15];
    logic [127:0] prev_rk, cur_rk, t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, p, m;
        r = '0;
        p = a;
        m = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (m[0]) r = r ^ p;
            p = xtime(p);
            m = m >> 1;
        end
        return r;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p, r;
        p = x;
        r = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] tw, n0, n1, n2, n3;
        tw = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        n0 = k[127:96] ^ tw;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] c);
        case (c)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte i sits at bits [127-8i -: 8]; row r of column c is byte r+4c
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        return {s[127:120], s[23:16],  s[47:40],  s[71:64],
                s[95:88],   s[119:112], s[15:8],  s[39:32],
                s[63:56],   s[87:80],  s[111:104], s[7:0],
                s[31:24],   s[55:48],  s[79:72],  s[103:96]};
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o, v;
        o = '0;
        v = s;
        for (int unsigned i = 0; i < 16; i++) begin
            o = {o[119:0], inv_sbox(v[127:120])};
            v = v << 8;
        end
        return o;
    endfunction

    function automatic logic [7:0] gmul_c(input logic [7:0] x, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00)
             ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? x : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul_c(a0, 4'hE) ^ gmul_c(a1, 4'hB) ^ gmul_c(a2, 4'hD) ^ gmul_c(a3, 4'h9),
                gmul_c(a0, 4'h9) ^ gmul_c(a1, 4'hE) ^ gmul_c(a2, 4'hB) ^ gmul_c(a3, 4'hD),
                gmul_c(a0, 4'hD) ^ gmul_c(a1, 4'h9) ^ gmul_c(a2, 4'hE) ^ gmul_c(a3, 4'hB),
                gmul_c(a0, 4'hB) ^ gmul_c(a1, 4'hD) ^ gmul_c(a2, 4'h9) ^ gmul_c(a3, 4'hE)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction

    // rk[0] is never stored; the key constant stands in for it
    always_comb begin
        prev_rk = (cnt == 4'd1) ? KEY : rk[cnt - 4'd1];
        cur_rk  = (cnt == 4'd0) ? KEY : rk[cnt];
        t       = inv_sub_bytes(inv_shift_rows(st)) ^ cur_rk;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= KEYGEN;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        Din_ready = 1'b0;
        case (state)
            KEYGEN: if (cnt == 4'd10) state_nx = IDLE;
            IDLE: begin
                Din_ready = 1'b1;
                if (Din_valid && en) state_nx = ROUND;
            end
            ROUND:  if (en && cnt == 4'd0) state_nx = IDLE;
            default: state_nx = KEYGEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && state == KEYGEN) rk[cnt] <= expand(prev_rk, rcon(cnt));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= 4'd1;
            st         <= '0;
            Dout       <= '0;
            Dout_valid <= 1'b0;
        end else begin
            Dout_valid <= 1'b0;
            case (state)
                KEYGEN: cnt <= cnt + 4'd1;
                IDLE: begin
                    if (Din_valid && en) begin
                        st  <= Din ^ rk[10];
                        cnt <= 4'd9;
                    end
                end
                ROUND: begin
                    if (en) begin
                        if (cnt != 4'd0) begin
                            st  <= inv_mix_columns(t);
                            cnt <= cnt - 4'd1;
                        end else begin
                            st         <= t;
                            Dout       <= t;
                            Dout_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed and randomized checks of aes_dec_iter against a byte-level
// AES-128 model (encrypt and decrypt) held in the bench.
module tb_aes_dec_iter;

    localparam logic [127:0] KEY   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] C1_CT = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899AABBCCDDEEFF;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b1;
    logic [127:0] Din = '0;
    logic         Din_valid = 1'b0;
    logic         Din_ready;
    logic [127:0] Dout;
    logic         Dout_valid;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] rks [16];

    aes_dec_iter #(.KEY(KEY)) dut (
        .clk(clk), .rst(rst), .en(en), .Din(Din), .Din_valid(Din_valid),
        .Din_ready(Din_ready), .Dout(Dout), .Dout_valid(Dout_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00, aa = a, bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) r ^= aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] b, input int n);
        return (b >> n) | (b << (8 - n));
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] v, input int i);
        logic [127:0] s = v << (8 * i);
        return s[127:120];
    endfunction

    function automatic logic [127:0] pb(input logic [127:0] v, input int i, input logic [7:0] b);
        int sh = 8 * (15 - i);
        return (v & ~(128'hFF << sh)) | ({120'b0, b} << sh);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
        logic [127:0] o = '0;
        for (int i = 0; i < 16; i++) o = pb(o, i, inv ? isb[gb(v, i)] : sb[gb(v, i)]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] v, input bit inv);
        logic [127:0] o = '0;
        int src;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) begin
                src = inv ? (c - rr + 4) % 4 : (c + rr) % 4;
                o = pb(o, rr + 4 * c, gb(v, rr + 4 * src));
            end
        return o;
    endfunction

    function automatic logic [7:0] coef(input bit inv, input int d);
        case (d)
            0: return inv ? 8'h0e : 8'h02;
            1: return inv ? 8'h0b : 8'h03;
            2: return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] v, input bit inv);
        logic [127:0] o = '0;
        logic [7:0] acc;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= tb_mul(coef(inv, (k - rr + 4) % 4), gb(v, k + 4 * c));
                o = pb(o, rr + 4 * c, acc);
            end
        return o;
    endfunction

    function automatic logic [127:0] menc(input logic [127:0] p);
        logic [127:0] s = p ^ rks[0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            s = shift_rows(sub_bytes(s, 0), 0);
            if (rnd < 10) s = mix(s, 0);
            s ^= rks[4'(rnd)];
        end
        return s;
    endfunction

    function automatic logic [127:0] mdec(input logic [127:0] c);
        logic [127:0] s = c ^ rks[10];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            s = sub_bytes(shift_rows(s, 1), 1);
            s ^= rks[4'(rnd)];
            if (rnd > 0) s = mix(s, 1);
        end
        return s;
    endfunction

    task automatic build_model();
        logic [7:0]  x, inv, rc;
        logic [31:0] tmp;
        logic [31:0] w [$];
        for (int xi = 0; xi < 256; xi++) begin
            x = 8'(xi);
            inv = 8'h00;
            for (int yi = 1; yi < 256; yi++)
                if (tb_mul(x, 8'(yi)) == 8'h01) inv = 8'(yi);
            sb[x] = inv ^ rotr(inv, 4) ^ rotr(inv, 5) ^ rotr(inv, 6) ^ rotr(inv, 7) ^ 8'h63;
        end
        for (int xi = 0; xi < 256; xi++) isb[sb[8'(xi)]] = 8'(xi);
        for (int i = 0; i < 4; i++) w.push_back(32'(KEY >> (32 * (3 - i))));
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc = tb_mul(rc, 8'h02);
            end
            w.push_back(w[i - 4] ^ tmp);
        end
        for (int k = 0; k <= 10; k++)
            rks[4'(k)] = {w[4 * k], w[4 * k + 1], w[4 * k + 2], w[4 * k + 3]};
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 30 && !Din_ready; i++) tick();
        chk({tag, " ready"}, Din_ready, 1'b1);
    endtask

    // Called in the first cycle after reset is released
    task automatic keygen_check(input string tag);
        for (int i = 1; i <= 11; i++) begin
            chk({tag, " ready"}, Din_ready, i == 11);
            chk({tag, " valid"}, Dout_valid, 1'b0);
            chk({tag, " dout"}, Dout, '0);
            if (i < 11) tick();
        end
    endtask

    task automatic do_block(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                            input int stall_at, input int stall_len, input bit busy);
        int lat = 10 + stall_len;
        wait_ready(tag);
        Din = ct; Din_valid = 1'b1; en = 1'b1;
        tick();
        Din_valid = 1'b0;
        for (int j = 1; j <= lat; j++) begin
            en = !(stall_len > 0 && j >= stall_at && j < stall_at + stall_len);
            if (busy && j == 3) begin
                Din = {$urandom, $urandom, $urandom, $urandom};
                Din_valid = 1'b1;
            end else Din_valid = 1'b0;
            tick();
            chk({tag, " valid"}, Dout_valid, j == lat);
        end
        en = 1'b1; Din_valid = 1'b0;
        chk({tag, " dout"}, Dout, pt);
        tick();
        chk({tag, " pulse"}, Dout_valid, 1'b0);
        chk({tag, " hold"}, Dout, pt);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] c2, p, c;
        int spurious;

        build_model();

        // T1: reset and key expansion window
        rst = 1'b0;
        tick(); tick();
        chk("reset ready", Din_ready, 1'b0);
        chk("reset dout", Dout, '0);
        chk("reset valid", Dout_valid, 1'b0);
        rst = 1'b1;
        keygen_check("T1");

        // Din_valid with en low must not be taken
        Din = C1_CT; Din_valid = 1'b1; en = 1'b0;
        tick();
        chk("en0 not accepted", Din_ready, 1'b1);
        Din_valid = 1'b0; en = 1'b1;

        // T2: FIPS-197 C.1
        do_block("T2", C1_CT, C1_PT, 0, 0, 0);

        // T3: back-to-back with Din_valid held
        c2 = menc('0);
        wait_ready("T3");
        Din = C1_CT; Din_valid = 1'b1; en = 1'b1;
        tick();
        Din = c2;
        for (int j = 1; j <= 21; j++) begin
            tick();
            chk("T3 valid", Dout_valid, j == 10 || j == 21);
            if (j == 10) begin
                chk("T3 dout1", Dout, C1_PT);
                chk("T3 ready with valid", Din_ready, 1'b1);
            end
            if (j == 21) chk("T3 dout2", Dout, '0);
        end
        Din_valid = 1'b0;
        tick();

        // T4: five stalled cycles after round 4
        do_block("T4", C1_CT, C1_PT, 5, 5, 0);

        // T5: input during ROUND is dropped
        do_block("T5", C1_CT, C1_PT, 0, 0, 1);
        spurious = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (Dout_valid) spurious++;
        end
        chk("T5 no second result", 128'(spurious), '0);

        // T6: reset during round 5
        wait_ready("T6");
        Din = C1_CT; Din_valid = 1'b1; en = 1'b1;
        tick();
        Din_valid = 1'b0;
        for (int j = 1; j <= 4; j++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        keygen_check("T6");
        do_block("T6 rerun", C1_CT, C1_PT, 0, 0, 0);

        // Randomized blocks with random stalls
        for (int n = 0; n < 6; n++) begin
            if (n % 2 == 0) begin
                p = {$urandom, $urandom, $urandom, $urandom};
                c = menc(p);
            end else begin
                c = {$urandom, $urandom, $urandom, $urandom};
                p = mdec(c);
            end
            do_block("rand", c, p, int'($urandom_range(1, 10)), int'($urandom_range(0, 3)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
